// File: rtl/controlador_acceso.sv
// Single-gate access controller: PIN-strobed opening, wrong-PIN alarm, tailgating block and lot occupancy.
// Optional open-gate timeout alarm is built when OPEN_TIMEOUT_EN is defined.
module controlador_acceso #(
    parameter int unsigned      PIN_W        = 8,
    parameter logic [PIN_W-1:0] PIN_CORRECT  = PIN_W'(8'h08),
    parameter int unsigned      MAX_TRIES    = 3,
    parameter int unsigned      CAPACITY     = 16,
    parameter int unsigned      OPEN_TIMEOUT = 1000
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic [PIN_W-1:0]                   Pin,
    input  logic                               Pin_valid,
    input  logic                               Vehiculo,
    input  logic                               Termino,
    input  logic                               Salida,
    output logic                               Cerrado,
    output logic                               Abierto,
    output logic                               Alarma,
    output logic                               Bloqueo,
    output logic                               Lleno,
    output logic [$clog2(MAX_TRIES+1)-1:0]     Intentos,
    output logic [$clog2(CAPACITY+1)-1:0]      Ocupacion
);

    localparam int unsigned IW = $clog2(MAX_TRIES + 1);
    localparam int unsigned OW = $clog2(CAPACITY + 1);

    typedef enum logic [1:0] {
        CERRADA   = 2'd0,
        ABIERTA   = 2'd1,
        BLOQUEADA = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   intentos_q, intentos_d;
    logic [OW-1:0]   ocupacion_q, ocupacion_d;
    logic            cerrado_q, cerrado_d;
    logic            abierto_q, abierto_d;
    logic            alarma_q, alarma_d;
    logic            bloqueo_q, bloqueo_d;
    logic            lleno_q, lleno_d;
    logic            pin_ok_c;
    logic            entrada_c;

`ifdef OPEN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(OPEN_TIMEOUT + 1);
    logic [TW-1:0]   timer_q, timer_d;
`else
    logic            unused_timeout_c;
    assign unused_timeout_c = (OPEN_TIMEOUT == 0);
`endif

    assign pin_ok_c = Pin_valid && (Pin == PIN_CORRECT);

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= CERRADA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, wrong-PIN counter and entry detection
    always_comb begin
        state_d    = state_q;
        intentos_d = intentos_q;
        entrada_c  = 1'b0;
        case (state_q)
            CERRADA: begin
                if (Pin_valid && Vehiculo) begin
                    if (Pin == PIN_CORRECT) begin
                        if (!lleno_q) begin
                            state_d    = ABIERTA;
                            intentos_d = '0;
                        end
                    end else if (intentos_q != IW'(MAX_TRIES)) begin
                        intentos_d = intentos_q + IW'(1);
                    end
                end
            end
            ABIERTA: begin
                if (Termino) begin
                    entrada_c = 1'b1;
                    state_d   = Vehiculo ? BLOQUEADA : CERRADA;
                end
            end
            BLOQUEADA: begin
                if (pin_ok_c && !lleno_q) begin
                    state_d = ABIERTA;
                end
            end
            default: state_d = CERRADA;
        endcase
    end

    // Next values of occupancy, timer and the registered outputs
    always_comb begin
        ocupacion_d = ocupacion_q;
        if (entrada_c && !Salida) begin
            if (ocupacion_q != OW'(CAPACITY)) begin
                ocupacion_d = ocupacion_q + OW'(1);
            end
        end else if (!entrada_c && Salida) begin
            if (ocupacion_q != '0) begin
                ocupacion_d = ocupacion_q - OW'(1);
            end
        end
        lleno_d = (ocupacion_d == OW'(CAPACITY));

`ifdef OPEN_TIMEOUT_EN
        timer_d = '0;
        if ((state_q == ABIERTA) && (state_d == ABIERTA)) begin
            timer_d = (timer_q == TW'(OPEN_TIMEOUT)) ? timer_q : timer_q + TW'(1);
        end
`endif

        cerrado_d = (state_d != ABIERTA);
        abierto_d = (state_d == ABIERTA);
        bloqueo_d = (state_d == BLOQUEADA);
        alarma_d  = 1'b0;
        case (state_d)
            CERRADA:   alarma_d = (intentos_d == IW'(MAX_TRIES));
`ifdef OPEN_TIMEOUT_EN
            ABIERTA:   alarma_d = (timer_d == TW'(OPEN_TIMEOUT));
`else
            ABIERTA:   alarma_d = 1'b0;
`endif
            BLOQUEADA: alarma_d = 1'b1;
            default:   alarma_d = 1'b0;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            intentos_q  <= '0;
            ocupacion_q <= '0;
            cerrado_q   <= 1'b1;
            abierto_q   <= 1'b0;
            alarma_q    <= 1'b0;
            bloqueo_q   <= 1'b0;
            lleno_q     <= 1'b0;
`ifdef OPEN_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            intentos_q  <= intentos_d;
            ocupacion_q <= ocupacion_d;
            cerrado_q   <= cerrado_d;
            abierto_q   <= abierto_d;
            alarma_q    <= alarma_d;
            bloqueo_q   <= bloqueo_d;
            lleno_q     <= lleno_d;
`ifdef OPEN_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign Cerrado   = cerrado_q;
    assign Abierto   = abierto_q;
    assign Alarma    = alarma_q;
    assign Bloqueo   = bloqueo_q;
    assign Lleno     = lleno_q;
    assign Intentos  = intentos_q;
    assign Ocupacion = ocupacion_q;

endmodule

// File: tb/tb_controlador_acceso.sv
// Directed bench for controlador_acceso with a two-slot lot and a 10-cycle open timeout.
module tb_controlador_acceso;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] Pin;
    logic       Pin_valid;
    logic       Vehiculo;
    logic       Termino;
    logic       Salida;
    logic       Cerrado, Abierto, Alarma, Bloqueo, Lleno;
    logic [1:0] Intentos;
    logic [1:0] Ocupacion;

    int checks = 0;
    int errors = 0;

    controlador_acceso #(
        .PIN_W(8), .PIN_CORRECT(8'h08), .MAX_TRIES(3), .CAPACITY(2), .OPEN_TIMEOUT(10)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Pin(Pin), .Pin_valid(Pin_valid),
        .Vehiculo(Vehiculo), .Termino(Termino), .Salida(Salida),
        .Cerrado(Cerrado), .Abierto(Abierto), .Alarma(Alarma), .Bloqueo(Bloqueo),
        .Lleno(Lleno), .Intentos(Intentos), .Ocupacion(Ocupacion)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic strobe_pin(input logic [7:0] p);
        Pin = p; Pin_valid = 1'b1;
        tick();
        Pin_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Pin = '0; Pin_valid = 0; Vehiculo = 0; Termino = 0; Salida = 0;
        #12;
        checks++; if (Cerrado !== 1'b1) begin errors++; $display("FAIL reset_cerrado got %b exp 1", Cerrado); end
        checks++; if (Abierto !== 1'b0) begin errors++; $display("FAIL reset_abierto got %b exp 0", Abierto); end
        checks++; if ({Alarma, Bloqueo, Lleno} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {Alarma, Bloqueo, Lleno}); end
        checks++; if ({Intentos, Ocupacion} !== 4'h0) begin errors++; $display("FAIL reset_counts got %h exp 0", {Intentos, Ocupacion}); end
        @(negedge Clk); Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_entry();
        Vehiculo = 1'b0;
        strobe_pin(8'h08);
        checks++; if (Cerrado !== 1'b1) begin errors++; $display("FAIL no_vehicle_ignored got %b exp 1", Cerrado); end
        Vehiculo = 1'b1;
        strobe_pin(8'h08);
        checks++; if ({Abierto, Cerrado, Alarma} !== 3'b100) begin errors++; $display("FAIL open_outputs got %b exp 100", {Abierto, Cerrado, Alarma}); end
        Vehiculo = 1'b0; Termino = 1'b1;
        tick();
        Termino = 1'b0;
        checks++; if ({Cerrado, Abierto} !== 2'b10) begin errors++; $display("FAIL entry_closed got %b exp 10", {Cerrado, Abierto}); end
        checks++; if (Ocupacion !== 2'd1) begin errors++; $display("FAIL entry_ocupacion got %0d exp 1", Ocupacion); end
        checks++; if (Lleno !== 1'b0) begin errors++; $display("FAIL entry_lleno got %b exp 0", Lleno); end
    endtask

    task automatic test_wrong_pins();
        logic [1:0] exp_int [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        logic       exp_alm [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        Vehiculo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe_pin(8'h11);
            checks++; if (Intentos !== exp_int[i]) begin errors++; $display("FAIL wrong_intentos_%0d got %0d exp %0d", i, Intentos, exp_int[i]); end
            checks++; if (Alarma !== exp_alm[i]) begin errors++; $display("FAIL wrong_alarma_%0d got %b exp %b", i, Alarma, exp_alm[i]); end
            checks++; if (Cerrado !== 1'b1) begin errors++; $display("FAIL wrong_cerrado_%0d got %b exp 1", i, Cerrado); end
        end
        strobe_pin(8'h08);
        checks++; if ({Abierto, Alarma, Intentos} !== 4'b1000) begin errors++; $display("FAIL clear_after_alarm got %b exp 1000", {Abierto, Alarma, Intentos}); end
    endtask

    task automatic test_tailgate();
        Vehiculo = 1'b1; Termino = 1'b1;
        tick();
        Termino = 1'b0;
        checks++; if ({Cerrado, Abierto, Bloqueo, Alarma} !== 4'b1011) begin errors++; $display("FAIL tailgate_outputs got %b exp 1011", {Cerrado, Abierto, Bloqueo, Alarma}); end
        checks++; if ({Ocupacion, Lleno} !== 3'b101) begin errors++; $display("FAIL tailgate_full got %b exp 101", {Ocupacion, Lleno}); end
        strobe_pin(8'h08);
        checks++; if ({Bloqueo, Abierto} !== 2'b10) begin errors++; $display("FAIL blocked_full_pin got %b exp 10", {Bloqueo, Abierto}); end
        strobe_pin(8'h55);
        checks++; if ({Bloqueo, Alarma, Intentos} !== 4'b1100) begin errors++; $display("FAIL blocked_wrong_pin got %b exp 1100", {Bloqueo, Alarma, Intentos}); end
        Salida = 1'b1;
        tick();
        Salida = 1'b0;
        checks++; if ({Ocupacion, Lleno, Bloqueo} !== 4'b0101) begin errors++; $display("FAIL blocked_salida got %b exp 0101", {Ocupacion, Lleno, Bloqueo}); end
        strobe_pin(8'h08);
        checks++; if ({Abierto, Cerrado, Bloqueo, Alarma} !== 4'b1000) begin errors++; $display("FAIL unblock got %b exp 1000", {Abierto, Cerrado, Bloqueo, Alarma}); end
    endtask

    task automatic test_timeout();
        logic exp_alarm;
`ifdef OPEN_TIMEOUT_EN
        exp_alarm = 1'b1;
`else
        exp_alarm = 1'b0;
`endif
        Vehiculo = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++; if ({Abierto, Alarma} !== 2'b10) begin errors++; $display("FAIL timeout_early got %b exp 10", {Abierto, Alarma}); end
        tick();
        checks++; if ({Abierto, Alarma} !== {1'b1, exp_alarm}) begin errors++; $display("FAIL timeout_alarm got %b exp %b", {Abierto, Alarma}, {1'b1, exp_alarm}); end
        Termino = 1'b1;
        tick();
        Termino = 1'b0;
        checks++; if ({Cerrado, Alarma, Ocupacion, Lleno} !== 5'b10101) begin errors++; $display("FAIL timeout_close got %b exp 10101", {Cerrado, Alarma, Ocupacion, Lleno}); end
    endtask

    task automatic test_full();
        Vehiculo = 1'b1;
        strobe_pin(8'h08);
        checks++; if ({Cerrado, Abierto, Intentos} !== 4'b1000) begin errors++; $display("FAIL full_refuse got %b exp 1000", {Cerrado, Abierto, Intentos}); end
        Vehiculo = 1'b0; Salida = 1'b1;
        tick();
        checks++; if ({Ocupacion, Lleno} !== 3'b010) begin errors++; $display("FAIL salida_1 got %b exp 010", {Ocupacion, Lleno}); end
        tick();
        checks++; if (Ocupacion !== 2'd0) begin errors++; $display("FAIL salida_0 got %0d exp 0", Ocupacion); end
        tick();
        Salida = 1'b0;
        checks++; if (Ocupacion !== 2'd0) begin errors++; $display("FAIL salida_sat got %0d exp 0", Ocupacion); end
        Vehiculo = 1'b1;
        strobe_pin(8'h08);
        Vehiculo = 1'b0; Termino = 1'b1;
        tick();
        Termino = 1'b0;
        checks++; if (Ocupacion !== 2'd1) begin errors++; $display("FAIL reentry got %0d exp 1", Ocupacion); end
        Vehiculo = 1'b1;
        strobe_pin(8'h08);
        Vehiculo = 1'b0; Termino = 1'b1; Salida = 1'b1; Pin = 8'h08; Pin_valid = 1'b1;
        tick();
        Termino = 1'b0; Salida = 1'b0; Pin_valid = 1'b0;
        checks++; if ({Cerrado, Ocupacion, Lleno} !== 4'b1010) begin errors++; $display("FAIL entry_and_salida got %b exp 1010", {Cerrado, Ocupacion, Lleno}); end
    endtask

    task automatic test_async_reset();
        Vehiculo = 1'b1;
        strobe_pin(8'h08);
        Vehiculo = 1'b0;
        checks++; if (Abierto !== 1'b1) begin errors++; $display("FAIL pre_reset_open got %b exp 1", Abierto); end
        #2 Reset_n = 1'b0;
        #1;
        checks++; if ({Cerrado, Abierto, Ocupacion} !== 4'b1000) begin errors++; $display("FAIL async_reset got %b exp 1000", {Cerrado, Abierto, Ocupacion}); end
        #1 Reset_n = 1'b1;
        tick();
        checks++; if ({Cerrado, Abierto, Alarma} !== 3'b100) begin errors++; $display("FAIL post_reset got %b exp 100", {Cerrado, Abierto, Alarma}); end
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_wrong_pins();
        test_tailgate();
        test_timeout();
        test_full();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
